// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: tracks F0/E0 prefixes, Shift and Caps Lock,
// translates make codes to ASCII and queues them in a first-word-fall-through FIFO.
module ps2_key_decoder #(
   parameter int         FIFO_AW      = 2,
   parameter bit         EMIT_UNKNOWN = 1'b1,
   parameter logic [7:0] UNKNOWN_CHAR = 8'h2a
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] scan_code,
   input  logic       scan_valid,
   input  logic       rd,
   input  logic       clr_ovf,
   output logic [7:0] rd_data,
   output logic       empty,
   output logic       full,
   output logic       shift,
   output logic       caps_lock,
   output logic       overflow
);

   localparam int DEPTH = 2 ** FIFO_AW;

   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

   state_t             state;
   logic               shift_l, shift_r;
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW:0]   wr_ptr, rd_ptr;
   logic               map_hit, is_letter;
   logic [7:0]         base_ch, xlat_ch;
   logic               push_req, do_push, do_pop;
   logic [7:0]         push_data;

   // Returns {hit, unshifted lowercase ASCII}.
   function automatic logic [8:0] base_map(input logic [7:0] code);
      case (code)
         8'h45: return {1'b1, 8'h30};  8'h16: return {1'b1, 8'h31};
         8'h1e: return {1'b1, 8'h32};  8'h26: return {1'b1, 8'h33};
         8'h25: return {1'b1, 8'h34};  8'h2e: return {1'b1, 8'h35};
         8'h36: return {1'b1, 8'h36};  8'h3d: return {1'b1, 8'h37};
         8'h3e: return {1'b1, 8'h38};  8'h46: return {1'b1, 8'h39};
         8'h1c: return {1'b1, 8'h61};  8'h32: return {1'b1, 8'h62};
         8'h21: return {1'b1, 8'h63};  8'h23: return {1'b1, 8'h64};
         8'h24: return {1'b1, 8'h65};  8'h2b: return {1'b1, 8'h66};
         8'h34: return {1'b1, 8'h67};  8'h33: return {1'b1, 8'h68};
         8'h43: return {1'b1, 8'h69};  8'h3b: return {1'b1, 8'h6a};
         8'h42: return {1'b1, 8'h6b};  8'h4b: return {1'b1, 8'h6c};
         8'h3a: return {1'b1, 8'h6d};  8'h31: return {1'b1, 8'h6e};
         8'h44: return {1'b1, 8'h6f};  8'h4d: return {1'b1, 8'h70};
         8'h15: return {1'b1, 8'h71};  8'h2d: return {1'b1, 8'h72};
         8'h1b: return {1'b1, 8'h73};  8'h2c: return {1'b1, 8'h74};
         8'h3c: return {1'b1, 8'h75};  8'h2a: return {1'b1, 8'h76};
         8'h1d: return {1'b1, 8'h77};  8'h22: return {1'b1, 8'h78};
         8'h35: return {1'b1, 8'h79};  8'h1a: return {1'b1, 8'h7a};
         8'h0e: return {1'b1, 8'h60};  8'h4e: return {1'b1, 8'h2d};
         8'h55: return {1'b1, 8'h3d};  8'h54: return {1'b1, 8'h5b};
         8'h5b: return {1'b1, 8'h5d};  8'h5d: return {1'b1, 8'h5c};
         8'h4c: return {1'b1, 8'h3b};  8'h52: return {1'b1, 8'h27};
         8'h41: return {1'b1, 8'h2c};  8'h49: return {1'b1, 8'h2e};
         8'h4a: return {1'b1, 8'h2f};  8'h29: return {1'b1, 8'h20};
         8'h5a: return {1'b1, 8'h0d};  8'h66: return {1'b1, 8'h08};
         default: return 9'h000;
      endcase
   endfunction

   // Shifted form of a non-letter; space, Enter and Backspace pass through.
   function automatic logic [7:0] shift_map(input logic [7:0] ch);
      case (ch)
         8'h31: return 8'h21;  8'h32: return 8'h40;  8'h33: return 8'h23;
         8'h34: return 8'h24;  8'h35: return 8'h25;  8'h36: return 8'h5e;
         8'h37: return 8'h26;  8'h38: return 8'h2a;  8'h39: return 8'h28;
         8'h30: return 8'h29;  8'h60: return 8'h7e;  8'h2d: return 8'h5f;
         8'h3d: return 8'h2b;  8'h5b: return 8'h7b;  8'h5d: return 8'h7d;
         8'h5c: return 8'h7c;  8'h3b: return 8'h3a;  8'h27: return 8'h22;
         8'h2c: return 8'h3c;  8'h2e: return 8'h3e;  8'h2f: return 8'h3f;
         default: return ch;
      endcase
   endfunction

   assign shift = shift_l | shift_r;

   always_comb begin
      {map_hit, base_ch} = base_map(scan_code);
      is_letter = (base_ch >= 8'h61) && (base_ch <= 8'h7a);
      if (is_letter)
         xlat_ch = (shift ^ caps_lock) ? (base_ch - 8'h20) : base_ch;
      else if (shift)
         xlat_ch = shift_map(base_ch);
      else
         xlat_ch = base_ch;
   end

   // Push request for the byte presented this cycle, using pre-update modifiers.
   always_comb begin
      push_req  = 1'b0;
      push_data = xlat_ch;
      if (scan_valid) begin
         case (state)
            IDLE: begin
               if (!(scan_code inside {8'hf0, 8'he0, 8'h12, 8'h59, 8'h58})) begin
                  if (map_hit) begin
                     push_req = 1'b1;
                  end else if (EMIT_UNKNOWN) begin
                     push_req  = 1'b1;
                     push_data = UNKNOWN_CHAR;
                  end
               end
            end
            EXT: begin
               if (scan_code == 8'h5a) begin
                  push_req  = 1'b1;
                  push_data = 8'h0d;
               end else if (scan_code == 8'h4a) begin
                  push_req  = 1'b1;
                  push_data = 8'h2f;
               end
            end
            default: push_req = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         shift_l   <= 1'b0;
         shift_r   <= 1'b0;
         caps_lock <= 1'b0;
      end else if (scan_valid) begin
         case (state)
            IDLE: begin
               case (scan_code)
                  8'hf0: state <= BRK;
                  8'he0: state <= EXT;
                  8'h12: shift_l <= 1'b1;
                  8'h59: shift_r <= 1'b1;
                  8'h58: caps_lock <= ~caps_lock;
                  default: state <= IDLE;
               endcase
            end
            BRK: begin
               if (scan_code == 8'h12) shift_l <= 1'b0;
               if (scan_code == 8'h59) shift_r <= 1'b0;
               state <= IDLE;
            end
            EXT:     state <= (scan_code == 8'hf0) ? EXT_BRK : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Pointers carry a wrap bit so full and empty are distinguishable.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr == {~rd_ptr[FIFO_AW], rd_ptr[FIFO_AW-1:0]});
   assign do_pop  = rd && !empty;
   assign do_push = push_req && (!full || do_pop);
   assign rd_data = mem[rd_ptr[FIFO_AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= push_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push_req && !do_push) overflow <= 1'b1;
         else if (clr_ovf)         overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: expected characters are queued as bytes are
// sent and a monitor process pops the FIFO and compares against the queue.
module tb_ps2_key_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] scan_code;
   logic       scan_valid, scan_valid_u;
   logic       man_rd, mon_rd, rd, clr_ovf, auto_rd;
   logic [7:0] rd_data, u_rd_data;
   logic       empty, full, shift, caps_lock, overflow;
   logic       u_empty, u_full, u_shift, u_caps, u_ovf;

   logic [7:0] exp_q[$];
   int         n_vec  = 0;
   int         n_fail = 0;

   assign rd = man_rd | mon_rd;

   always #5 clk = ~clk;

   ps2_key_decoder #(.FIFO_AW(2), .EMIT_UNKNOWN(1'b1), .UNKNOWN_CHAR(8'h2a)) dut (
      .clk(clk), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
      .rd(rd), .clr_ovf(clr_ovf), .rd_data(rd_data), .empty(empty), .full(full),
      .shift(shift), .caps_lock(caps_lock), .overflow(overflow)
   );

   ps2_key_decoder #(.FIFO_AW(2), .EMIT_UNKNOWN(1'b0), .UNKNOWN_CHAR(8'h2a)) dut_u (
      .clk(clk), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid_u),
      .rd(1'b0), .clr_ovf(1'b0), .rd_data(u_rd_data), .empty(u_empty), .full(u_full),
      .shift(u_shift), .caps_lock(u_caps), .overflow(u_ovf)
   );

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      scan_code  = b;
      scan_valid = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0;
   endtask

   task automatic send_u(input logic [7:0] b);
      @(negedge clk);
      scan_code    = b;
      scan_valid_u = 1'b1;
      @(negedge clk);
      scan_valid_u = 1'b0;
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 60) begin
         @(negedge clk);
         k++;
      end
      repeat (4) @(negedge clk);
      chk("drain_left", 8'(exp_q.size()), 8'd0);
   endtask

   // Monitor: pops whenever the FIFO shows a character and auto reading is on.
   initial begin
      logic [7:0] e;
      mon_rd = 1'b0;
      forever begin
         @(negedge clk);
         mon_rd = 1'b0;
         if (auto_rd && !reset && !empty) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL fifo_extra: got %h expected none", rd_data);
            end else begin
               e = exp_q.pop_front();
               chk("fifo_data", rd_data, e);
            end
            mon_rd = 1'b1;
         end
      end
   end

   initial begin
      logic [7:0] e;
      reset = 1'b1; scan_code = 8'h00; scan_valid = 1'b0; scan_valid_u = 1'b0;
      man_rd = 1'b0; clr_ovf = 1'b0; auto_rd = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_empty", {7'b0, empty}, 8'd1);
      chk("rst_full", {7'b0, full}, 8'd0);
      chk("rst_shift", {7'b0, shift}, 8'd0);
      chk("rst_caps", {7'b0, caps_lock}, 8'd0);
      chk("rst_ovf", {7'b0, overflow}, 8'd0);
      reset = 1'b0;
      auto_rd = 1'b1;

      // make then break of 'a'
      exp_q.push_back(8'h61);
      send(8'h1c);
      chk("empty_after_make", {7'b0, empty}, 8'd0);
      send(8'hf0); send(8'h1c);
      wait_drain();

      // Shift with digits and punctuation
      send(8'h12);
      chk("shift_held", {7'b0, shift}, 8'd1);
      exp_q.push_back(8'h21); send(8'h16);
      exp_q.push_back(8'h5f); send(8'h4e);
      exp_q.push_back(8'h7c); send(8'h5d);
      exp_q.push_back(8'h20); send(8'h29);
      send(8'hf0); send(8'h12);
      chk("shift_released", {7'b0, shift}, 8'd0);
      exp_q.push_back(8'h31); send(8'h16);
      // right shift
      send(8'h59);
      exp_q.push_back(8'h3f); send(8'h4a);
      send(8'hf0); send(8'h59);
      chk("shift_r_released", {7'b0, shift}, 8'd0);
      wait_drain();

      // Caps Lock against letters and digits
      send(8'h58); send(8'hf0); send(8'h58);
      chk("caps_on", {7'b0, caps_lock}, 8'd1);
      exp_q.push_back(8'h41); send(8'h1c);
      send(8'h12);
      exp_q.push_back(8'h61); send(8'h1c);
      send(8'hf0); send(8'h12);
      exp_q.push_back(8'h31); send(8'h16);
      wait_drain();

      // Extended codes
      exp_q.push_back(8'h0d); send(8'he0); send(8'h5a);
      send(8'he0); send(8'hf0); send(8'h5a);
      send(8'he0); send(8'h75);
      exp_q.push_back(8'h2f); send(8'he0); send(8'h4a);
      wait_drain();

      // Caps off, then fill and overflow with reads held off
      send(8'h58); send(8'hf0); send(8'h58);
      chk("caps_off", {7'b0, caps_lock}, 8'd0);
      auto_rd = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         if (i < 4) exp_q.push_back(8'h61);
         send(8'h1c);
         if (i == 2) chk("not_full_3", {7'b0, full}, 8'd0);
         if (i == 3) begin
            chk("full_4", {7'b0, full}, 8'd1);
            chk("no_ovf_4", {7'b0, overflow}, 8'd0);
         end
         if (i == 4) chk("ovf_5", {7'b0, overflow}, 8'd1);
      end
      @(negedge clk);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      chk("ovf_cleared", {7'b0, overflow}, 8'd0);

      // Simultaneous push and pop while full
      e = exp_q.pop_front();
      chk("head_full", rd_data, e);
      scan_code = 8'h45; scan_valid = 1'b1; man_rd = 1'b1;
      exp_q.push_back(8'h30);
      @(negedge clk);
      scan_valid = 1'b0; man_rd = 1'b0;
      chk("full_after_rw", {7'b0, full}, 8'd1);
      chk("ovf_after_rw", {7'b0, overflow}, 8'd0);
      auto_rd = 1'b1;
      wait_drain();

      // Unknown code on both instances
      exp_q.push_back(8'h2a); send(8'h07);
      wait_drain();
      send_u(8'h07);
      repeat (2) @(negedge clk);
      chk("u_unknown_dropped", {7'b0, u_empty}, 8'd1);
      send_u(8'h1c);
      chk("u_mapped_pushed", {7'b0, u_empty}, 8'd0);
      chk("u_mapped_data", u_rd_data, 8'h61);

      // Reset in the middle of a break sequence
      send(8'hf0);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      chk("u_reset_empty", {7'b0, u_empty}, 8'd1);
      exp_q.push_back(8'h61); send(8'h1c);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
